// File: rtl/char_motion_ctrl_if.sv
// Movement and pixel-query bundle between the game-state FSM / compositor (master)
// and the character motion controller (slave).
interface char_motion_ctrl_if;
    logic [1:0]  direction;
    logic        charIsMoving;
    logic        charIsRunning;
    logic [1:0]  charMoveFrame;
    logic [3:0]  state_num;
    logic        blocked;
    logic [9:0]  DRAWX;
    logic [9:0]  DRAWY;
    logic [9:0]  mapX;
    logic [9:0]  mapY;
    logic [1:0]  facing;
    logic        stepping;
    logic        is_char_pixel;
    logic [11:0] sprite_addr;

    modport master (
        output direction, charIsMoving, charIsRunning, charMoveFrame,
               state_num, blocked, DRAWX, DRAWY,
        input  mapX, mapY, facing, stepping, is_char_pixel, sprite_addr
    );

    modport slave (
        input  direction, charIsMoving, charIsRunning, charMoveFrame,
               state_num, blocked, DRAWX, DRAWY,
        output mapX, mapY, facing, stepping, is_char_pixel, sprite_addr
    );
endinterface

// File: rtl/char_motion_ctrl.sv
// Tile-aligned character motion driven by VGA frame ticks, with collision/map-edge
// blocking, plus the registered sprite ROM address / hit flag for the draw pixel.
module char_motion_ctrl #(
    parameter int unsigned TILE       = 16,
    parameter logic [9:0]  MAP_MAX_X  = 10'd624,
    parameter logic [9:0]  MAP_MAX_Y  = 10'd464,
    parameter logic [9:0]  START_X    = 10'd160,
    parameter logic [9:0]  START_Y    = 10'd160,
    parameter logic [9:0]  CHAR_X0    = 10'd312,
    parameter logic [9:0]  CHAR_Y0    = 10'd232,
    parameter logic [3:0]  BUMP_TICKS = 4'd8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic VGA_VS,
    char_motion_ctrl_if.slave mv
);

    typedef enum logic [1:0] {IDLE, STEP, BUMP} state_t;

    state_t      state;
    logic [1:0]  vs_sync;
    logic        vs_prev;
    logic        tick;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [1:0]  facing_r;
    logic        stepping_r;
    logic [1:0]  speed;
    logic [5:0]  remaining;
    logic [3:0]  bump_cnt;
    logic        edge_hit;
    logic [10:0] right_end;
    logic [10:0] down_end;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        pix_hit;
    logic [1:0]  anim;
    logic        pix_hit_r;
    logic [11:0] sprite_addr_r;

    // VGA_VS is asynchronous; tick fires once per frame on its synchronized rising edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_sync <= 2'b00;
            vs_prev <= 1'b0;
        end else begin
            vs_sync <= {vs_sync[0], VGA_VS};
            vs_prev <= vs_sync[1];
        end
    end

    assign tick = vs_sync[1] & ~vs_prev;

    assign right_end = {1'b0, pos_x} + 11'(TILE);
    assign down_end  = {1'b0, pos_y} + 11'(TILE);

    // A step is rejected up front if the full tile move would leave the map.
    always_comb begin
        edge_hit = 1'b0;
        case (mv.direction)
            2'd0: edge_hit = down_end > {1'b0, MAP_MAX_Y};
            2'd1: edge_hit = pos_y < 10'(TILE);
            2'd2: edge_hit = pos_x < 10'(TILE);
            2'd3: edge_hit = right_end > {1'b0, MAP_MAX_X};
            default: edge_hit = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            pos_x      <= START_X;
            pos_y      <= START_Y;
            facing_r   <= 2'd0;
            stepping_r <= 1'b0;
            speed      <= 2'd1;
            remaining  <= 6'd0;
            bump_cnt   <= 4'd0;
        end else if (tick) begin
            if (mv.state_num == 4'd0) begin
                state      <= IDLE;
                pos_x      <= START_X;
                pos_y      <= START_Y;
                facing_r   <= 2'd0;
                stepping_r <= 1'b0;
                remaining  <= 6'd0;
                bump_cnt   <= 4'd0;
            end else if (mv.state_num == 4'd3) begin
                case (state)
                    IDLE: begin
                        if (mv.charIsMoving) begin
                            facing_r <= mv.direction;
                            if (mv.blocked || edge_hit) begin
                                state    <= BUMP;
                                bump_cnt <= BUMP_TICKS;
                            end else begin
                                state      <= STEP;
                                stepping_r <= 1'b1;
                                speed      <= mv.charIsRunning ? 2'd2 : 2'd1;
                                remaining  <= 6'(TILE);
                            end
                        end
                    end
                    STEP: begin
                        case (facing_r)
                            2'd0: pos_y <= pos_y + 10'(speed);
                            2'd1: pos_y <= pos_y - 10'(speed);
                            2'd2: pos_x <= pos_x - 10'(speed);
                            default: pos_x <= pos_x + 10'(speed);
                        endcase
                        if (remaining <= {4'd0, speed}) begin
                            remaining  <= 6'd0;
                            state      <= IDLE;
                            stepping_r <= 1'b0;
                        end else begin
                            remaining <= remaining - {4'd0, speed};
                        end
                    end
                    BUMP: begin
                        if (bump_cnt <= 4'd1) begin
                            bump_cnt <= 4'd0;
                            state    <= IDLE;
                        end else begin
                            bump_cnt <= bump_cnt - 4'd1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        stepping_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Unsigned wrap makes pixels left/above the box land far outside 0..15.
    assign col     = mv.DRAWX - CHAR_X0;
    assign row     = mv.DRAWY - CHAR_Y0;
    assign pix_hit = (col[9:4] == 6'd0) && (row[9:4] == 6'd0);
    assign anim    = (state == STEP) ? mv.charMoveFrame : 2'd0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_hit_r     <= 1'b0;
            sprite_addr_r <= 12'd0;
        end else begin
            pix_hit_r     <= pix_hit;
            sprite_addr_r <= pix_hit ? {facing_r, anim, row[3:0], col[3:0]} : 12'd0;
        end
    end

    assign mv.mapX          = pos_x;
    assign mv.mapY          = pos_y;
    assign mv.facing        = facing_r;
    assign mv.stepping      = stepping_r;
    assign mv.is_char_pixel = pix_hit_r;
    assign mv.sprite_addr   = sprite_addr_r;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Scoreboard bench for char_motion_ctrl: directed stimulus queues hand-computed
// expectations; a monitor pops and compares them against the settled DUT outputs.
module tb_char_motion_ctrl;

    typedef struct {
        bit          pix;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [1:0]  f;
        logic        s;
        logic        hit;
        logic [11:0] addr;
    } exp_t;

    logic Clk;
    logic Reset;
    logic VGA_VS;
    int   total;
    int   bad;
    exp_t sb[$];

    char_motion_ctrl_if bus();

    char_motion_ctrl dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .VGA_VS (VGA_VS),
        .mv     (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: outputs are settled whenever an expectation is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.pix) begin
                    check_output("is_char_pixel", {11'd0, bus.is_char_pixel}, {11'd0, e.hit});
                    check_output("sprite_addr", bus.sprite_addr, e.addr);
                end else begin
                    check_output("mapX", {2'd0, bus.mapX}, {2'd0, e.x});
                    check_output("mapY", {2'd0, bus.mapY}, {2'd0, e.y});
                    check_output("facing", {10'd0, bus.facing}, {10'd0, e.f});
                    check_output("stepping", {11'd0, bus.stepping}, {11'd0, e.s});
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic frame();
        @(negedge Clk) VGA_VS = 1'b1;
        repeat (6) @(negedge Clk);
        VGA_VS = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    task automatic expect_motion(input int x, input int y, input int f, input bit s);
        exp_t e;
        e.pix = 1'b0; e.x = 10'(x); e.y = 10'(y); e.f = 2'(f); e.s = s;
        e.hit = 1'b0; e.addr = 12'd0;
        sb.push_back(e);
        drain();
    endtask

    task automatic expect_pixel(input int dx, input int dy, input bit hit, input logic [11:0] addr);
        exp_t e;
        @(negedge Clk);
        bus.DRAWX = 10'(dx);
        bus.DRAWY = 10'(dy);
        repeat (2) @(negedge Clk);
        e.pix = 1'b1; e.x = 10'd0; e.y = 10'd0; e.f = 2'd0; e.s = 1'b0;
        e.hit = hit; e.addr = addr;
        sb.push_back(e);
        drain();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        VGA_VS = 1'b0;
        bus.direction = 2'd0;
        bus.charIsMoving = 1'b0;
        bus.charIsRunning = 1'b0;
        bus.charMoveFrame = 2'd0;
        bus.state_num = 4'd0;
        bus.blocked = 1'b0;
        bus.DRAWX = 10'd0;
        bus.DRAWY = 10'd0;
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        expect_motion(160, 160, 0, 0);
        expect_pixel(0, 0, 0, 12'h000);

        // Walking step right; a mid-step direction change must be ignored.
        bus.state_num = 4'd3;
        bus.direction = 2'd3;
        bus.charIsMoving = 1'b1;
        frame();
        expect_motion(160, 160, 3, 1);
        for (int i = 1; i <= 16; i++) begin
            if (i == 5) bus.direction = 2'd1;
            frame();
            expect_motion(160 + i, 160, 3, i < 16);
        end
        bus.charIsMoving = 1'b0;
        bus.direction = 2'd3;

        expect_pixel(312, 232, 1, 12'hC00);
        expect_pixel(328, 232, 0, 12'h000);
        expect_pixel(327, 247, 1, 12'hCFF);
        expect_pixel(311, 232, 0, 12'h000);
        expect_pixel(312, 248, 0, 12'h000);

        // Running step down; dropping run mid-step keeps speed 2.
        bus.direction = 2'd0;
        bus.charIsRunning = 1'b1;
        bus.charIsMoving = 1'b1;
        bus.charMoveFrame = 2'd2;
        frame();
        expect_motion(176, 160, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) bus.charIsRunning = 1'b0;
            frame();
            expect_motion(176, 160 + 2 * i, 0, i < 8);
            if (i == 4) expect_pixel(315, 234, 1, 12'h223);
            if (i == 4) bus.charIsMoving = 1'b0;
        end
        expect_pixel(315, 234, 1, 12'h023);

        // Collision bump: 8 ticks of BUMP, step accepted on the 9th.
        bus.direction = 2'd1;
        bus.blocked = 1'b1;
        bus.charIsMoving = 1'b1;
        frame();
        expect_motion(176, 176, 1, 0);
        bus.blocked = 1'b0;
        bus.direction = 2'd3;
        for (int i = 1; i <= 8; i++) begin
            frame();
            expect_motion(176, 176, 1, 0);
        end
        frame();
        expect_motion(176, 176, 3, 1);
        bus.charIsMoving = 1'b0;
        repeat (16) frame();
        expect_motion(192, 176, 3, 0);

        // Left map edge.
        bus.direction = 2'd2;
        bus.charIsRunning = 1'b1;
        bus.charIsMoving = 1'b1;
        repeat (12 * 9) frame();
        expect_motion(0, 176, 2, 0);
        frame();
        expect_motion(0, 176, 2, 0);
        bus.direction = 2'd3;
        frame();
        expect_motion(0, 176, 2, 0);
        bus.charIsMoving = 1'b0;
        repeat (8) frame();

        // Right map edge.
        bus.direction = 2'd3;
        bus.charIsMoving = 1'b1;
        repeat (39 * 9) frame();
        expect_motion(624, 176, 3, 0);
        frame();
        expect_motion(624, 176, 3, 0);
        bus.direction = 2'd2;
        frame();
        expect_motion(624, 176, 3, 0);
        bus.charIsMoving = 1'b0;
        repeat (8) frame();

        // Start screen mid-step reloads the start position.
        bus.direction = 2'd2;
        bus.charIsRunning = 1'b0;
        bus.charIsMoving = 1'b1;
        frame();
        expect_motion(624, 176, 2, 1);
        bus.charIsMoving = 1'b0;
        repeat (8) frame();
        expect_motion(616, 176, 2, 1);
        bus.state_num = 4'd0;
        frame();
        expect_motion(160, 160, 0, 0);

        // Fade state freezes a step in progress.
        bus.state_num = 4'd3;
        bus.direction = 2'd3;
        bus.charIsMoving = 1'b1;
        frame();
        expect_motion(160, 160, 3, 1);
        bus.charIsMoving = 1'b0;
        repeat (4) frame();
        expect_motion(164, 160, 3, 1);
        bus.state_num = 4'd2;
        for (int i = 0; i < 3; i++) begin
            frame();
            expect_motion(164, 160, 3, 1);
        end
        bus.state_num = 4'd3;
        repeat (12) frame();
        expect_motion(176, 160, 3, 0);

        // Reset held across a frame edge wins over motion.
        bus.direction = 2'd1;
        bus.charIsMoving = 1'b1;
        Reset = 1'b1;
        frame();
        Reset = 1'b0;
        expect_motion(160, 160, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/char_motion_ctrl.md
Name: char_motion_ctrl

Overview:
Consumer side of the game-state FSM's movement interface. It takes the per-frame direction, moving, running and animation-frame signals and turns them into tile-aligned world motion of the player character, with collision and map-edge blocking. It also produces the character sprite ROM address and pixel-hit flag for the current VGA draw coordinate. It sits between the game-state FSM and the sprite/background compositor.

Parameters:
TILE, 16, pixels per tile step; every step moves exactly TILE pixels
MAP_MAX_X, 10'd624, largest legal world X for the character's top-left corner
MAP_MAX_Y, 10'd464, largest legal world Y for the character's top-left corner
START_X, 10'd160, world X loaded on reset and on the start screen
START_Y, 10'd160, world Y loaded on reset and on the start screen
CHAR_X0, 10'd312, fixed screen X of the character's top-left corner
CHAR_Y0, 10'd232, fixed screen Y of the character's top-left corner
BUMP_TICKS, 4'd8, number of frame ticks held in BUMP

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high
VGA_VS  in  1  VGA vertical sync, asynchronous to Clk
direction  in  2  0 down, 1 up, 2 left, 3 right
charIsMoving  in  1  movement key held
charIsRunning  in  1  run modifier
charMoveFrame  in  2  walk animation frame 0..2
state_num  in  4  game state: 0 start, 2 fade, 3 main game
blocked  in  1  tile ahead in `direction` is solid (from map lookup)
DRAWX  in  10  current VGA pixel X
DRAWY  in  10  current VGA pixel Y
mapX  out  10  character world X (top-left)
mapY  out  10  character world Y (top-left)
facing  out  2  latched facing direction
stepping  out  1  high while in STEP
is_char_pixel  out  1  DRAWX/DRAWY lies inside the 16x16 character box
sprite_addr  out  12  sprite ROM address, formed as {facing, anim, row[3:0], col[3:0]}

Behaviour:
- Frame tick: VGA_VS passes through a 2-flop synchronizer; tick is a single Clk-cycle pulse on the synchronized rising edge. All motion updates occur only on tick cycles.
- Reset values: mapX=START_X, mapY=START_Y, facing=0, state IDLE, stepping=0, is_char_pixel=0, sprite_addr=0, remaining=0, bump counter=0, synchronizer flops=0.
- state_num==0 on a tick: mapX/mapY reload to START, FSM goes to IDLE, facing=0. This overrides everything else, including a step in progress.
- state_num not in {0,3}: FSM and position freeze; no transitions.
- IDLE, tick, state_num==3, charIsMoving=1:
  - facing <= direction.
  - If blocked=1, or the move would leave [0, MAP_MAX], go to BUMP with counter=BUMP_TICKS; position is unchanged.
  - Otherwise go to STEP: latch speed (2 if charIsRunning, else 1) and set remaining=TILE.
- STEP, each tick:
  - Position moves by speed in facing direction; remaining -= speed.
  - When remaining reaches 0, go to IDLE on the same tick. Inputs are re-evaluated only on the following tick, so one idle tick separates chained steps.
  - direction, charIsMoving, charIsRunning and blocked are ignored mid-step. The speed latched at step start is kept for the whole step.
- BUMP: counter decrements each tick; at 0 go to IDLE. No motion.
- stepping = (state==STEP).
- anim = charMoveFrame in STEP, else 0.
- Pixel path, registered with 1 Clk latency:
  - col = DRAWX-CHAR_X0, row = DRAWY-CHAR_Y0, both 10-bit unsigned.
  - is_char_pixel = (col<16)&&(row<16).
  - sprite_addr = {facing, anim, row[3:0], col[3:0]} when hit, else 0.
- Tick coincident with Reset: Reset wins.

Test Plan:
- Reset, then state_num=3, direction=3, moving=1, blocked=0 for 16 ticks -> mapX 160→176 in 1-px increments, stepping=1 for 16 ticks, then 0; facing=3.
- charIsRunning=1 at step start, direction=0 -> mapY 160→176 in 8 ticks (+2 each); dropping charIsRunning mid-step keeps +2.
- blocked=1, direction=1 -> facing=1, mapY unchanged, FSM in BUMP for 8 ticks; no step is accepted until the 9th tick.
- mapX=0, direction=2 -> BUMP, mapX stays 0; at mapX=624, direction=3 -> BUMP.
- Mid-step (remaining=8), state_num→0 -> next tick mapX=160, mapY=160, stepping=0; state_num=2 mid-step -> position frozen until state_num returns to 3.
- DRAWX=312, DRAWY=232, facing=3, IDLE -> one cycle later is_char_pixel=1, sprite_addr=12'hC00; DRAWX=328 -> is_char_pixel=0, sprite_addr=0.
